// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder: adds two W-bit operands plus carry-in, one 4-bit
// carry-lookahead slice per cycle, with valid/ready handshakes on both sides.
module nibble_serial_adder #(
  parameter int unsigned N_NIB = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*N_NIB-1:0]   a,
  input  logic [4*N_NIB-1:0]   b,
  input  logic                 ci,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*N_NIB:0]     sum,
  output logic                 ovf
);

  localparam int unsigned W  = 4 * N_NIB;
  localparam int unsigned KW = (N_NIB > 1) ? $clog2(N_NIB) : 1;
  localparam logic [KW-1:0] KLast = KW'(N_NIB - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [KW-1:0]   k_q, k_d;
  logic            carry_q, carry_d;
  logic [W:0]      sum_q, sum_d;
  logic            ovf_q, ovf_d;

  logic [3:0]      nib_a, nib_b, nib_g, nib_p, nib_s;
  logic [4:0]      c;

  // Select nibble k of the captured operands and add it with 4-bit lookahead carries.
  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int i = 0; i < N_NIB; i++) begin
      if (k_q == KW'(i)) begin
        nib_a = a_q[4*i +: 4];
        nib_b = b_q[4*i +: 4];
      end
    end
    nib_g = nib_a & nib_b;
    nib_p = nib_a ^ nib_b;
    c[0]  = carry_q;
    c[1]  = nib_g[0] | (nib_p[0] & c[0]);
    c[2]  = nib_g[1] | (nib_p[1] & nib_g[0]) | (nib_p[1] & nib_p[0] & c[0]);
    c[3]  = nib_g[2] | (nib_p[2] & nib_g[1]) | (nib_p[2] & nib_p[1] & nib_g[0])
          | (nib_p[2] & nib_p[1] & nib_p[0] & c[0]);
    c[4]  = nib_g[3] | (nib_p[3] & nib_g[2]) | (nib_p[3] & nib_p[2] & nib_g[1])
          | (nib_p[3] & nib_p[2] & nib_p[1] & nib_g[0])
          | (nib_p[3] & nib_p[2] & nib_p[1] & nib_p[0] & c[0]);
    nib_s = nib_p ^ c[3:0];
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    k_d       = k_q;
    carry_d   = carry_q;
    sum_d     = sum_q;
    ovf_d     = ovf_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = ci;
          k_d     = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        for (int i = 0; i < N_NIB; i++) begin
          if (k_q == KW'(i)) begin
            sum_d[4*i +: 4] = nib_s;
          end
        end
        carry_d = c[4];
        k_d     = k_q + 1'b1;
        if (k_q == KLast) begin
          sum_d[W] = c[4];
          // Signed overflow: carry into the sign bit differs from carry out of it.
          ovf_d    = c[3] ^ c[4];
          k_d      = '0;
          state_d  = StDone;
        end
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      k_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sum = sum_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder: a driver issues operands and pushes
// the arithmetic expectation; a monitor pops and compares on each result handshake.
module tb_nibble_serial_adder;

  localparam int N_NIB = 4;
  localparam int W     = 4 * N_NIB;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         ci = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W:0]   sum;
  logic         ovf;

  nibble_serial_adder #(.N_NIB(N_NIB)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ci        (ci),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W:0] s;
    logic       o;
    int         acc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   hold_left = 0;
  bit   rand_ready = 1'b0;
  bit   busy_hi = 1'b0;
  int   first_acc = 0;
  int   last_acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: plain integer arithmetic on unsigned and signed views.
  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic cv, input int acc);
    exp_t   m;
    longint ua, ub, sa, sb, half, full, st;
    full = longint'(1) << W;
    half = longint'(1) << (W - 1);
    ua   = longint'(av);
    ub   = longint'(bv);
    sa   = (ua >= half) ? ua - full : ua;
    sb   = (ub >= half) ? ub - full : ub;
    st   = sa + sb + longint'(cv);
    m.s   = (W+1)'(ua + ub + longint'(cv));
    m.o   = (st > half - 1) || (st < -half);
    m.acc = acc;
    return m;
  endfunction

  task automatic check(input string name, input logic [W:0] got, input logic [W:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // One clock step; inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (out_valid && hold_left > 0) begin
      out_ready = 1'b0;
      hold_left--;
    end else if (out_valid && !rand_ready) begin
      out_ready = 1'b1;
    end else begin
      out_ready = 1'($urandom_range(0, 1));
    end
    if (in_ready) begin
      in_valid = 1'b0;
    end else begin
      in_valid = busy_hi ? 1'b1 : 1'($urandom_range(0, 1));
      a        = W'($urandom);
      b        = W'($urandom);
      ci       = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
    int n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      errors++;
      checks++;
      $display("FAIL issue_timeout: in_ready %b expected 1", in_ready);
    end else begin
      a        = av;
      b        = bv;
      ci       = cv;
      in_valid = 1'b1;
      last_acc = cyc + 1;
      q.push_back(model(av, bv, cv, cyc + 1));
      tick();
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 200) begin
      tick();
      n++;
    end
    if (q.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain_timeout: %0d results outstanding expected 0", q.size());
      q.delete();
    end
  endtask

  // Monitor: samples on the falling edge, compares results at each handshake.
  logic       prev_valid = 1'b0;
  logic       hs_pend = 1'b0;
  logic [W:0] prev_sum = '0;
  logic       prev_ovf = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      hs_pend    = 1'b0;
    end else begin
      if (hs_pend) begin
        check("post_handshake_out_valid", (W+1)'(out_valid), '0);
        check("post_handshake_in_ready", (W+1)'(in_ready), 1);
      end
      hs_pend = 1'b0;
      if (out_valid) begin
        check("ready_valid_exclusive", (W+1)'(in_ready), '0);
        if (!prev_valid) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: sum %h with empty scoreboard", sum);
          end else begin
            check("latency", (W+1)'(cyc - q[0].acc), (W+1)'(N_NIB));
          end
        end else begin
          check("hold_sum", sum, prev_sum);
          check("hold_ovf", (W+1)'(ovf), (W+1)'(prev_ovf));
        end
        if (out_ready && q.size() > 0) begin
          exp_t e;
          e = q.pop_front();
          check("sum", sum, e.s);
          check("ovf", (W+1)'(ovf), (W+1)'(e.o));
          hs_pend = 1'b1;
        end
      end
      prev_valid = out_valid;
      prev_sum   = sum;
      prev_ovf   = ovf;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    tick();
    tick();
    check("reset_in_ready", (W+1)'(in_ready), 1);
    check("reset_out_valid", (W+1)'(out_valid), '0);
    check("reset_sum", sum, '0);
    check("reset_ovf", (W+1)'(ovf), '0);
    rst = 1'b0;

    // Directed corner cases.
    issue(16'hFFFF, 16'h0001, 1'b0);
    drain();
    issue(16'h7FFF, 16'h0001, 1'b0);
    drain();
    issue(16'h8000, 16'h8000, 1'b0);
    drain();
    issue(16'h1234, 16'h4321, 1'b1);
    drain();

    // Back-pressure with in_valid held high while busy.
    busy_hi   = 1'b1;
    hold_left = 5;
    issue(16'hA5A5, 16'h5A5B, 1'b1);
    drain();
    busy_hi   = 1'b0;
    hold_left = 0;

    // Reset during the second RUN cycle discards the operation.
    issue(16'h1234, 16'h1111, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    void'(q.pop_back());
    check("midreset_in_ready", (W+1)'(in_ready), 1);
    check("midreset_out_valid", (W+1)'(out_valid), '0);
    check("midreset_sum", sum, '0);
    check("midreset_ovf", (W+1)'(ovf), '0);
    issue(16'h0F0F, 16'h00F1, 1'b0);
    drain();

    // Back-to-back random operations: one accepted every 6 cycles.
    issue(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
    first_acc = last_acc;
    for (int i = 1; i < 1000; i++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
    end
    check("b2b_throughput", (W+1)'(last_acc - first_acc), (W+1)'(6 * 999));
    drain();

    // Random consumer back-pressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
    end
    drain();

    tick();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 SHALL have parameter N_NIB, default 4, meaning the number of 4-bit nibbles per operand; the operand width W = 4*N_NIB.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-004 SHALL have port in_valid, input, 1, operand set presented.
REQ-005 SHALL have port in_ready, output, 1, block can accept an operand set.
REQ-006 SHALL have port a, input, W, addend A.
REQ-007 SHALL have port b, input, W, addend B.
REQ-008 SHALL have port ci, input, 1, carry-in.
REQ-009 SHALL have port out_valid, output, 1, result held on sum/ovf.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-011 SHALL have port sum, output, W+1, result; sum[W] is the final carry-out.
REQ-012 SHALL have port ovf, output, 1, two's-complement overflow of the W-bit signed add.

Function
REQ-013 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-014 SHALL drive in_ready=1 only in IDLE, and out_valid=1 only in DONE.
REQ-015 SHALL, in IDLE with in_valid=1, capture a, b and ci into internal registers, clear nibble index k to 0, load the carry register with ci, and go to RUN.
REQ-016 SHALL, in RUN, add nibble k of A, nibble k of B and the carry register each cycle using 4-bit carry-lookahead logic (G=a&b, P=a^b, sum-lookahead carries).
REQ-017 SHALL, in RUN, write the resulting 4 sum bits to sum[4k+3:4k], load the carry register with the nibble carry-out, and increment k.
REQ-018 SHALL, after the cycle that processes nibble N_NIB-1, write sum[W] with that nibble's carry-out and set ovf = (carry into bit W-1) XOR (carry out of bit W-1), then go to DONE.
REQ-019 SHALL give a latency of exactly N_NIB cycles: operands accepted at edge T0 produce out_valid=1 after edge T0+N_NIB.
REQ-020 SHALL, in DONE, hold sum, ovf and out_valid stable while out_ready=0, for any duration.
REQ-021 SHALL, in DONE with out_ready=1, return to IDLE at that edge, so out_valid=0 and in_ready=1 in the next cycle.
REQ-022 SHALL NOT accept a new operand in the same cycle as the result handshake.
REQ-023 SHALL ignore in_valid while in RUN or DONE; a, b and ci changing during RUN SHALL NOT affect the result.
REQ-024 SHALL treat out_ready in IDLE or RUN as don't-care.
REQ-025 SHALL give sum equal to a+b+ci modulo 2^(W+1) for all inputs.
REQ-026 SHALL leave sum and ovf unchanged in IDLE from the last completed operation; their value is undefined outside DONE.

Reset
REQ-027 SHALL, with rst=1 at a clock edge, force IDLE, k=0, carry register 0, sum=0 and ovf=0.
REQ-028 SHALL give reset-time outputs in_ready=1 and out_valid=0.
REQ-029 SHALL abort any in-flight RUN or DONE operation on rst with no result delivered, and rst SHALL take priority over in_valid and out_ready.
REQ-030 SHALL return to normal operation on the first edge after rst deasserts.

Verification (N_NIB=4)
REQ-031 SHALL cover full-ripple carry: a=0xFFFF, b=0x0001, ci=0 -> sum=0x10000, ovf=0, out_valid 4 cycles after acceptance.
REQ-032 SHALL cover signed overflow: a=0x7FFF, b=0x0001, ci=0 -> sum=0x08000, ovf=1; and a=0x8000, b=0x8000 -> sum=0x10000, ovf=1.
REQ-033 SHALL cover carry-in: a=0x1234, b=0x4321, ci=1 -> sum=0x05556, ovf=0.
REQ-034 SHALL cover back-pressure: hold out_ready=0 for 5 cycles in DONE -> sum/ovf/out_valid stable; out_ready=1 -> IDLE next cycle; in_valid held high during the busy period is not accepted.
REQ-035 SHALL cover mid-operation reset: assert rst at the second RUN cycle -> next cycle in_ready=1, out_valid=0, sum=0; then a=0x0F0F, b=0x00F1 -> sum=0x01000.
REQ-036 SHALL cover back-to-back operations: present a new operand set immediately after each handshake -> one result per 6 cycles, all results correct against a+b+ci over 1000 random vectors.
